// File: rtl/menlo_presettable_counter_if.sv
// Control/status bundle for one menlo_presettable_counter stage.
// master drives the controls; slave is the counter itself.
interface menlo_presettable_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             SR_N;
  logic             SPE_N;
  logic             PE;
  logic             TE;
  logic             UD;
  logic [WIDTH-1:0] P;
  logic             OVF_CLR;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             OVF;

  modport master (
    output SR_N, SPE_N, PE, TE, UD, P, OVF_CLR,
    input  Q, TC, OVF
  );

  modport slave (
    input  SR_N, SPE_N, PE, TE, UD, P, OVF_CLR,
    output Q, TC, OVF
  );
endinterface

// File: rtl/menlo_presettable_counter.sv
// Parametrised 74xx163-style presettable counter: programmable modulus, up/down,
// wrap or saturate, sticky overflow, and a combinational TC for ripple cascading.
module menlo_presettable_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter bit          SATURATE = 1'b0
) (
  input logic                        CP,
  input logic                        MR,
  menlo_presettable_counter_if.slave bus
);

  if (WIDTH < 1 || MODULUS < 2 || 64'(MODULUS) > (64'(1) << WIDTH)) begin : g_bad_params
    $error("menlo_presettable_counter: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] TopVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_zero, tc, count_en;

  // ">=" so that an out-of-range preload still reports terminal count when counting up.
  assign at_top   = (q_q >= TopVal);
  assign at_zero  = (q_q == '0);
  assign tc       = bus.TE & (bus.UD ? at_top : at_zero);
  assign count_en = bus.SR_N & bus.SPE_N & bus.PE & bus.TE;

  always_comb begin
    q_d = q_q;
    if (!bus.SR_N) begin
      q_d = '0;
    end else if (!bus.SPE_N) begin
      q_d = bus.P;
    end else if (bus.PE && bus.TE) begin
      if (bus.UD) begin
        if (at_top) begin
          q_d = SATURATE ? q_q : '0;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q > TopVal) begin
          q_d = TopVal;
        end else if (at_zero) begin
          q_d = SATURATE ? q_q : TopVal;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  // A same-cycle set beats OVF_CLR.
  assign ovf_d = (count_en & tc) | (ovf_q & ~bus.OVF_CLR);

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.TC  = tc;
  assign bus.OVF = ovf_q;

endmodule
